// File: rtl/aes_seq_ctrl.sv
// Purpose: sequences one AES job: serial load of pt/key, wait for done, serial ciphertext read, timeout recovery.
// Latency: 8 load + wait cycles + 1 read request + RD_LAT + 3 read cycles, then the result is held in OUT.
// Backpressure: one job in flight; in_ready only in IDLE, and the result is held until out_ready.
module aes_seq_ctrl #(
    parameter int TIMEOUT     = 64,
    parameter int RD_LAT      = 2,
    parameter int RECOVER_CYC = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_pt,
    input  logic [127:0] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_ct,
    output logic         out_err,
    output logic         busy,
    output logic         core_reset_n,
    output logic         core_start_n,
    output logic         core_start_read_n,
    output logic [31:0]  core_dword_in,
    input  logic [31:0]  core_dword_out,
    input  logic         core_done
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        WAIT    = 3'd2,
        RDREQ   = 3'd3,
        READ    = 3'd4,
        RECOVER = 3'd5,
        OUT     = 3'd6
    } state_t;

    state_t        state;
    state_t        state_nxt;

    // One shared counter: load word index, wait cycles, read offset, recovery cycles.
    // It is cleared on every state change so each state starts counting from zero.
    logic [15:0]   cnt;
    logic [15:0]   cnt_nxt;

    logic [127:0]  pt_q;
    logic [127:0]  key_q;
    logic [127:0]  ct_q;
    logic          err_q;

    // READ starts the cycle after RDREQ, so the first capture is at cnt == RD_LAT-1.
    logic          rd_cap;
    logic [15:0]   rd_off;
    logic          rec_last;

    assign rd_off   = cnt - 16'(RD_LAT - 1);
    assign rd_cap   = (state == READ) && (cnt >= 16'(RD_LAT - 1));
    assign rec_last = (state == RECOVER) && (cnt == 16'(RECOVER_CYC - 1));

    assign out_ct  = ct_q;
    assign out_err = err_q;

    // State and counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 16'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state, counter update and all core/handshake strobes decoded from state.
    always_comb begin
        state_nxt         = state;
        cnt_nxt           = cnt + 16'd1;
        in_ready          = 1'b0;
        out_valid         = 1'b0;
        busy              = (state != IDLE);
        core_reset_n      = !reset;
        core_start_n      = 1'b1;
        core_start_read_n = 1'b1;
        core_dword_in     = 32'd0;
        case (state)
            IDLE: begin
                in_ready = !reset;
                cnt_nxt  = 16'd0;
                if (in_valid && !reset) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                case (cnt[2:0])
                    3'd0:    core_dword_in = pt_q[127:96];
                    3'd1:    core_dword_in = pt_q[95:64];
                    3'd2:    core_dword_in = pt_q[63:32];
                    3'd3:    core_dword_in = pt_q[31:0];
                    3'd4:    core_dword_in = key_q[127:96];
                    3'd5:    core_dword_in = key_q[95:64];
                    3'd6:    core_dword_in = key_q[63:32];
                    default: core_dword_in = key_q[31:0];
                endcase
                core_start_n = (cnt[2:0] != 3'd0);
                if (cnt[2:0] == 3'd7) begin
                    state_nxt = WAIT;
                    cnt_nxt   = 16'd0;
                end
            end
            WAIT: begin
                // Done wins over a timeout landing on the same edge.
                if (core_done) begin
                    state_nxt = RDREQ;
                    cnt_nxt   = 16'd0;
                end else if (cnt == 16'(TIMEOUT - 1)) begin
                    state_nxt = RECOVER;
                    cnt_nxt   = 16'd0;
                end
            end
            RDREQ: begin
                core_start_read_n = 1'b0;
                state_nxt         = READ;
                cnt_nxt           = 16'd0;
            end
            READ: begin
                if (rd_cap && (rd_off == 16'd3)) begin
                    state_nxt = OUT;
                    cnt_nxt   = 16'd0;
                end
            end
            RECOVER: begin
                core_reset_n = 1'b0;
                if (rec_last) begin
                    state_nxt = OUT;
                    cnt_nxt   = 16'd0;
                end
            end
            OUT: begin
                out_valid = 1'b1;
                cnt_nxt   = 16'd0;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 16'd0;
            end
        endcase
    end

    // Request latch, ciphertext assembly and error flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pt_q  <= 128'd0;
            key_q <= 128'd0;
            ct_q  <= 128'd0;
            err_q <= 1'b0;
        end else begin
            if ((state == IDLE) && in_valid) begin
                pt_q  <= in_pt;
                key_q <= in_key;
                err_q <= 1'b0;
            end
            if (rd_cap) begin
                case (rd_off[1:0])
                    2'd0:    ct_q[127:96] <= core_dword_out;
                    2'd1:    ct_q[95:64]  <= core_dword_out;
                    2'd2:    ct_q[63:32]  <= core_dword_out;
                    default: ct_q[31:0]   <= core_dword_out;
                endcase
            end
            if (rec_last) begin
                ct_q  <= 128'd0;
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_aes_seq_ctrl.sv
// Bench for aes_seq_ctrl: a behavioural AES-core model reacts to the controller's strobes,
// a host model drives requests and checks results, latency and output hold behaviour.
module tb_aes_seq_ctrl;

    localparam int TIMEOUT     = 64;
    localparam int RD_LAT      = 2;
    localparam int RECOVER_CYC = 2;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_pt = '0;
    logic [127:0] in_key = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_ct;
    logic         out_err;
    logic         busy;
    logic         core_reset_n;
    logic         core_start_n;
    logic         core_start_read_n;
    logic [31:0]  core_dword_in;
    logic [31:0]  core_dword_out = '0;
    logic         core_done = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    aes_seq_ctrl #(
        .TIMEOUT(TIMEOUT),
        .RD_LAT(RD_LAT),
        .RECOVER_CYC(RECOVER_CYC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_pt(in_pt),
        .in_key(in_key),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_ct(out_ct),
        .out_err(out_err),
        .busy(busy),
        .core_reset_n(core_reset_n),
        .core_start_n(core_start_n),
        .core_start_read_n(core_start_read_n),
        .core_dword_in(core_dword_in),
        .core_dword_out(core_dword_out),
        .core_done(core_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one cycle; inputs are driven and outputs sampled at the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [127:0] fake_ct(input logic [127:0] pt, input logic [127:0] key);
        return pt ^ {key[63:0], key[127:64]} ^ 128'h5a5a_0000_ffff_1234_0f0f_a5a5_3c3c_c3c3;
    endfunction

    // AES core model: takes 8 words after the start strobe, raises done on the d-th wait
    // cycle, answers a read strobe with the four ciphertext words RD_LAT cycles later.
    task automatic core_model(input logic [127:0] pt, input logic [127:0] key,
                              input logic [127:0] ct, input int d);
        logic [255:0] words;
        int n;
        int starts;
        int c;
        int rlow;
        words = {pt, key};
        n = 0;
        while (core_start_n !== 1'b0 && n < 40) begin
            step();
            n++;
        end
        check("core_start_seen", core_start_n, 1'b0);
        if (core_start_n !== 1'b0) return;
        starts = 0;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("load_word%0d", k), core_dword_in, words[255-32*k -: 32]);
            if (core_start_n == 1'b0) starts++;
            step();
        end
        check("start_low_cycles", starts, 1);
        c = 1;
        while (c <= TIMEOUT + 5) begin
            if (core_start_read_n == 1'b0 || core_reset_n == 1'b0) break;
            check("wait_dword_zero", core_dword_in, 32'd0);
            check("wait_start_high", core_start_n, 1'b1);
            core_done = (c >= d);
            step();
            c++;
        end
        core_done = 1'b0;
        if (d <= TIMEOUT) begin
            check("rdreq_cycle", c, d + 1);
            check("rdreq_strobe", core_start_read_n, 1'b0);
            check("rdreq_core_reset_n", core_reset_n, 1'b1);
            step();
            for (int j = 1; j <= RD_LAT + 3; j++) begin
                if (j >= RD_LAT) core_dword_out = ct[127-32*(j-RD_LAT) -: 32];
                else             core_dword_out = $urandom;
                check("read_strobe_high", core_start_read_n, 1'b1);
                step();
            end
            core_dword_out = $urandom;
        end else begin
            check("recover_cycle", c, TIMEOUT + 1);
            rlow = 0;
            while (core_reset_n == 1'b0 && rlow < 20) begin
                rlow++;
                step();
            end
            check("recover_low_cycles", rlow, RECOVER_CYC);
        end
    endtask

    // Host model: issues one request, measures latency, checks the result and the hold behaviour.
    task automatic host(input logic [127:0] pt, input logic [127:0] key,
                        input logic [127:0] exp_ct, input logic exp_err,
                        input int exp_lat, input int hold);
        int n;
        logic [127:0] first_ct;
        check("idle_in_ready", in_ready, 1'b1);
        in_valid  = 1'b1;
        in_pt     = pt;
        in_key    = key;
        out_ready = 1'b0;
        step();
        // Junk on the request inputs during the job must be ignored.
        in_valid = 1'(($urandom & 1));
        in_pt    = {$urandom, $urandom, $urandom, $urandom};
        in_key   = {$urandom, $urandom, $urandom, $urandom};
        check("job_busy", busy, 1'b1);
        check("job_in_ready", in_ready, 1'b0);
        n = 1;
        while (out_valid !== 1'b1 && n < 400) begin
            step();
            n++;
        end
        check("latency", n, exp_lat);
        check("out_ct", out_ct, exp_ct);
        check("out_err", out_err, exp_err);
        first_ct = out_ct;
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            step();
            check("hold_valid", out_valid, 1'b1);
            check("hold_ct", out_ct, first_ct);
            check("hold_err", out_err, exp_err);
            check("hold_in_ready", in_ready, 1'b0);
        end
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        check("idle_after_out_busy", busy, 1'b0);
        check("idle_after_out_in_ready", in_ready, 1'b1);
        check("out_valid_dropped", out_valid, 1'b0);
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic run_job(input logic [127:0] pt, input logic [127:0] key,
                           input logic [127:0] core_ct, input int d, input int hold);
        logic [127:0] exp_ct;
        logic         exp_err;
        int           exp_lat;
        if (d <= TIMEOUT) begin
            exp_ct  = core_ct;
            exp_err = 1'b0;
            exp_lat = 8 + d + 1 + RD_LAT + 4;
        end else begin
            exp_ct  = 128'd0;
            exp_err = 1'b1;
            exp_lat = 8 + TIMEOUT + RECOVER_CYC + 1;
        end
        fork
            host(pt, key, exp_ct, exp_err, exp_lat, hold);
            core_model(pt, key, core_ct, d);
        join
        step();
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_in_ready"}, in_ready, 1'b0);
        check({pfx, "_out_valid"}, out_valid, 1'b0);
        check({pfx, "_out_ct"}, out_ct, 128'd0);
        check({pfx, "_out_err"}, out_err, 1'b0);
        check({pfx, "_busy"}, busy, 1'b0);
        check({pfx, "_core_reset_n"}, core_reset_n, 1'b0);
        check({pfx, "_core_start_n"}, core_start_n, 1'b1);
        check({pfx, "_core_start_read_n"}, core_start_read_n, 1'b1);
        check({pfx, "_core_dword_in"}, core_dword_in, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] pt;
        logic [127:0] key;
        int d;
        // Reset state, then release and expect an immediately ready idle controller.
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        reset = 1'b0;
        #1;
        check("rel_in_ready", in_ready, 1'b1);
        check("rel_core_reset_n", core_reset_n, 1'b1);
        @(negedge clk);

        // FIPS-197 Appendix B.
        run_job(128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                128'h3925841d02dc09fbdc118597196a0b32, 10, 2);
        // FIPS-197 C.1, with the result held off for 10 cycles.
        run_job(128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
                128'h69c4e0d86a7b0430d8cdb78070b4c55a, 3, 10);
        // Core never finishes: timeout and recovery.
        run_job(128'h0123456789abcdef0123456789abcdef, 128'hfedcba9876543210fedcba9876543210,
                128'hdeadbeefdeadbeefdeadbeefdeadbeef, 1000, 1);
        // Done arrives exactly on the timeout edge.
        run_job(128'h11111111222222223333333344444444, 128'h55555555666666667777777788888888,
                fake_ct(128'h11111111222222223333333344444444, 128'h55555555666666667777777788888888),
                TIMEOUT, 0);

        // Reset pulsed in the middle of a wait.
        in_valid = 1'b1;
        in_pt    = {$urandom, $urandom, $urandom, $urandom};
        in_key   = {$urandom, $urandom, $urandom, $urandom};
        step();
        in_valid = 1'b0;
        repeat (20) step();
        check("midwait_busy", busy, 1'b1);
        #2 reset = 1'b1;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst_rel_in_ready", in_ready, 1'b1);
        check("midrst_rel_core_reset_n", core_reset_n, 1'b1);
        check("midrst_rel_out_valid", out_valid, 1'b0);
        @(negedge clk);
        run_job(128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                128'h3925841d02dc09fbdc118597196a0b32, 5, 1);

        // Randomised jobs, including some that time out.
        for (int i = 0; i < 10; i++) begin
            pt  = {$urandom, $urandom, $urandom, $urandom};
            key = {$urandom, $urandom, $urandom, $urandom};
            d   = $urandom_range(1, TIMEOUT + 6);
            run_job(pt, key, fake_ct(pt, key), d, $urandom_range(0, 5));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
